// File: rtl/bsg_rr_merge_2_width_p10_pkg.sv
// rtl/bsg_rr_merge_2_width_p10_pkg.sv - shared constants and types for the two-input round-robin merge
package bsg_rr_merge_2_width_p10_pkg;

  // The merge is built for exactly two producers.
  localparam int rr_merge_els_lp = 2;

  // Source index carried alongside each merged word.
  typedef logic rr_merge_tag_t;

  // Encodes a one-hot-or-zero two-bit grant as a source index.
  function automatic rr_merge_tag_t rr_merge_gnt_to_tag(input logic [1:0] gnt);
    return rr_merge_tag_t'(gnt[1]);
  endfunction

endpackage

// File: rtl/bsg_mux_one_hot.sv
// rtl/bsg_mux_one_hot.sv - and-or one-hot multiplexer
module bsg_mux_one_hot #(
  parameter int width_p = 10,
  parameter int els_p   = 2
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic [width_p-1:0]       data_o
);

  // OR together every input whose select bit is set; zero select yields zero.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < els_p; k++) begin
      data_o = data_o | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
    end
  end

endmodule

// File: rtl/bsg_rr_merge_2_width_p10_arb.sv
// rtl/bsg_rr_merge_2_width_p10_arb.sv - two-way round-robin arbiter holding the last-served index
module bsg_round_robin_arb_2
  import bsg_rr_merge_2_width_p10_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [1:0]    v_i,
  input  logic          accept_i,
  output logic [1:0]    gnt_o,
  output rr_merge_tag_t gnt_tag_o
);

  rr_merge_tag_t last_r;

  // A lone requester always wins; on contention the input after the last served one wins.
  always_comb begin
    gnt_o = 2'b00;
    unique case (v_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_r ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  assign gnt_tag_o = rr_merge_gnt_to_tag(gnt_o);

  // Priority rotates only when a word is actually taken, so a stalled grant keeps its turn.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_r <= 1'b1;
    end else if (accept_i && (v_i != 2'b00)) begin
      last_r <= gnt_tag_o;
    end
  end

endmodule

// File: rtl/bsg_rr_merge_2_width_p10.sv
// rtl/bsg_rr_merge_2_width_p10.sv - two-input round-robin merge into a single registered output slot
module bsg_rr_merge_2_width_p10
  import bsg_rr_merge_2_width_p10_pkg::*;
#(
  parameter int width_p = 10,
  parameter int els_p   = rr_merge_els_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic [els_p-1:0]         ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     tag_o,
  input  logic                     yumi_i
);

  if (els_p != 2) begin : g_els_check
    $error("bsg_rr_merge_2_width_p10 supports exactly two inputs");
  end

  logic               v_r;
  logic [width_p-1:0] data_r;
  rr_merge_tag_t      tag_r;

  logic               accept_en;
  logic [1:0]         gnt;
  rr_merge_tag_t      gnt_tag;
  logic [width_p-1:0] mux_data;
  logic               xfer;

  // The slot can take a word when empty or when it is being drained this cycle; never during reset.
  assign accept_en = (~v_r | yumi_i) & ~reset_i;

  bsg_round_robin_arb_2 arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .accept_i  (accept_en),
    .gnt_o     (gnt),
    .gnt_tag_o (gnt_tag)
  );

  assign ready_o = gnt & {2{accept_en}};
  assign xfer    = |ready_o;

  bsg_mux_one_hot #(
    .width_p (width_p),
    .els_p   (2)
  ) mux (
    .data_i        (data_i),
    .sel_one_hot_i (ready_o),
    .data_o        (mux_data)
  );

  // Output slot: load on transfer, empty on a drain with no refill, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
      tag_r  <= 1'b0;
    end else if (xfer) begin
      v_r    <= 1'b1;
      data_r <= mux_data;
      tag_r  <= gnt_tag;
    end else if (yumi_i) begin
      v_r    <= 1'b0;
    end
  end

  assign v_o    = v_r;
  assign data_o = data_r;
  assign tag_o  = tag_r;

`ifndef SYNTHESIS
  // Protocol checks: consumer must not take from an empty slot, and at most one input is granted.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_r)) else $error("yumi_i asserted while v_o is low");
      assert ($onehot0(ready_o)) else $error("ready_o is not one-hot-or-zero");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_rr_merge_2_width_p10.sv
// tb/tb_bsg_rr_merge_2_width_p10.sv - self-checking bench for the two-input round-robin merge
module tb_bsg_rr_merge_2_width_p10;

  logic        clk;
  logic        reset;
  logic [1:0]  v;
  logic [19:0] data;
  logic [1:0]  ready;
  logic        v_out;
  logic [9:0]  data_out;
  logic        tag_out;
  logic        yumi;

  int checks;
  int failures;

  // Reference state: what the output slot should hold and who was served last.
  bit       m_v;
  bit [9:0] m_data;
  bit       m_tag;
  bit       m_last;

  bsg_rr_merge_2_width_p10 dut (
    .clk_i   (clk),
    .reset_i (reset),
    .v_i     (v),
    .data_i  (data),
    .ready_o (ready),
    .v_o     (v_out),
    .data_o  (data_out),
    .tag_o   (tag_out),
    .yumi_i  (yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which input the rules say should be taken this cycle; -1 when none.
  function automatic int model_winner();
    if (reset) return -1;
    if (m_v && !yumi) return -1;
    if (v == 2'b11) return (m_last + 1) % 2;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] model_ready();
    int w;
    w = model_winner();
    if (w < 0) return 2'b00;
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  // Drive one cycle's inputs half a period before the rising edge, then let combinational outputs settle.
  task automatic apply(input bit r, input bit [1:0] vv, input bit [9:0] d0, input bit [9:0] d1, input bit y);
    @(negedge clk);
    reset = r;
    v     = vv;
    data  = {d1, d0};
    yumi  = y;
    #1;
  endtask

  // Move the reference model across the rising edge, then return to a quiet sampling point.
  task automatic advance();
    int w;
    w = model_winner();
    if (reset) begin
      m_v = 0; m_data = 0; m_tag = 0; m_last = 1;
    end else if (w >= 0) begin
      m_v = 1; m_data = data[w*10 +: 10]; m_tag = w[0]; m_last = w[0];
    end else if (yumi) begin
      m_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 2'b11, 10'h155, 10'h2AA, 0);
      checks++;
      if (ready !== 2'b00) begin
        failures++;
        $display("FAIL reset_ready cycle %0d: got %b want 00", i, ready);
      end
      advance();
      checks++;
      if (v_out !== 1'b0 || data_out !== 10'h000 || tag_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cycle %0d: got v=%b d=%h t=%b want v=0 d=000 t=0", i, v_out, data_out, tag_out);
      end
    end
    apply(0, 2'b00, 10'h0, 10'h0, 0);
    checks++;
    if (ready !== 2'b00) begin
      failures++;
      $display("FAIL idle_ready: got %b want 00", ready);
    end
    advance();
    checks++;
    if (v_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_v: got %b want 0", v_out);
    end
  endtask

  task automatic test_single_source();
    apply(0, 2'b01, 10'h155, 10'h000, 0);
    checks++;
    if (ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready: got %b want 01", ready);
    end
    advance();
    checks++;
    if (v_out !== 1'b1 || data_out !== 10'h155 || tag_out !== 1'b0) begin
      failures++;
      $display("FAIL single_out: got v=%b d=%h t=%b want v=1 d=155 t=0", v_out, data_out, tag_out);
    end
  endtask

  task automatic test_alternation();
    apply(1, 2'b00, 10'h0, 10'h0, 0);
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(0, 2'b11, 10'h0AA, 10'h3FF, (i != 0));
      checks++;
      if (ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL alt_ready step %0d: got %b want %b", i, ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      advance();
      checks++;
      if (v_out !== 1'b1 || tag_out !== i[0] || data_out !== ((i % 2 == 0) ? 10'h0AA : 10'h3FF)) begin
        failures++;
        $display("FAIL alt_out step %0d: got v=%b t=%b d=%h want v=1 t=%0d d=%h",
                 i, v_out, tag_out, data_out, i % 2, (i % 2 == 0) ? 10'h0AA : 10'h3FF);
      end
    end
  endtask

  // Enters with the slot holding 0x0AA from input 0.
  task automatic test_back_pressure();
    for (int i = 0; i < 3; i++) begin
      apply(0, 2'b11, 10'h111, 10'h222, 0);
      checks++;
      if (ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_ready step %0d: got %b want 00", i, ready);
      end
      advance();
      checks++;
      if (v_out !== 1'b1 || data_out !== 10'h0AA || tag_out !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold step %0d: got v=%b d=%h t=%b want v=1 d=0AA t=0", i, v_out, data_out, tag_out);
      end
    end
    apply(0, 2'b11, 10'h111, 10'h222, 1);
    checks++;
    if (ready !== 2'b10) begin
      failures++;
      $display("FAIL bp_release_ready: got %b want 10", ready);
    end
    advance();
    checks++;
    if (data_out !== 10'h222 || tag_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_out: got d=%h t=%b want d=222 t=1", data_out, tag_out);
    end
  endtask

  task automatic test_drain_and_load();
    apply(0, 2'b10, 10'h000, 10'h201, 1);
    checks++;
    if (ready !== 2'b10) begin
      failures++;
      $display("FAIL dl_ready: got %b want 10", ready);
    end
    advance();
    checks++;
    if (v_out !== 1'b1 || data_out !== 10'h201 || tag_out !== 1'b1) begin
      failures++;
      $display("FAIL dl_out: got v=%b d=%h t=%b want v=1 d=201 t=1", v_out, data_out, tag_out);
    end
  endtask

  task automatic test_reset_mid_stream();
    apply(0, 2'b01, 10'h155, 10'h000, 1);
    advance();
    checks++;
    if (data_out !== 10'h155 || v_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_fill: got v=%b d=%h want v=1 d=155", v_out, data_out);
    end
    apply(1, 2'b11, 10'h155, 10'h2AA, 1);
    checks++;
    if (ready !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_ready: got %b want 00", ready);
    end
    advance();
    checks++;
    if (v_out !== 1'b0 || data_out !== 10'h000) begin
      failures++;
      $display("FAIL mid_reset_state: got v=%b d=%h want v=0 d=000", v_out, data_out);
    end
    apply(0, 2'b11, 10'h155, 10'h2AA, 0);
    checks++;
    if (ready !== 2'b01) begin
      failures++;
      $display("FAIL mid_first_grant: got %b want 01", ready);
    end
    advance();
  endtask

  task automatic test_random();
    bit        r;
    bit        y;
    bit [1:0]  vv;
    bit [9:0]  d0;
    bit [9:0]  d1;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      vv = 2'($urandom_range(0, 3));
      d0 = 10'($urandom);
      d1 = 10'($urandom);
      y  = v_out && ($urandom_range(0, 2) != 0);
      apply(r, vv, d0, d1, y);
      checks++;
      if (ready !== model_ready()) begin
        failures++;
        $display("FAIL rand_ready cycle %0d: got %b want %b", i, ready, model_ready());
      end
      advance();
      checks++;
      if (v_out !== m_v || (m_v && (data_out !== m_data || tag_out !== m_tag))) begin
        failures++;
        $display("FAIL rand_out cycle %0d: got v=%b d=%h t=%b want v=%b d=%h t=%b",
                 i, v_out, data_out, tag_out, m_v, m_data, m_tag);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    v        = 2'b00;
    data     = '0;
    yumi     = 1'b0;
    m_v = 0; m_data = 0; m_tag = 0; m_last = 1;
    test_reset();
    test_single_source();
    test_alternation();
    test_back_pressure();
    test_drain_and_load();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_rr_merge_2_width_p10.md
Name: bsg_rr_merge_2_width_p10

Overview:
- Two-input round-robin merge stage that sits directly upstream of the 10-bit, 2-way one-hot mux in the datapath.
- Arbitrates between two valid/ready producers and generates the one-hot select that steers the mux.
- Registers the selected word, plus a source tag, into a single output slot consumed with valid/yumi.
- Gives fair, full-throughput sharing of one 10-bit channel between two sources.

Parameters:
- width_p, 10, data width per input and output.
- els_p, 2, number of inputs; fixed at 2, any other value is a compile-time error.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  els_p  per-input valid.
- data_i  input  els_p*width_p  input words; input k occupies bits [k*width_p +: width_p].
- ready_o  output  els_p  per-input ready; input k transfers in a cycle where v_i[k] & ready_o[k].
- v_o  output  1  output slot holds a word.
- data_o  output  width_p  registered output word.
- tag_o  output  1  index of the input that supplied data_o.
- yumi_i  input  1  consumer takes the word this cycle; legal only when v_o=1.

Behaviour:
- State: v_r, data_r[width_p-1:0], tag_r, last_r. Outputs: v_o=v_r, data_o=data_r, tag_o=tag_r.
- Reset, sampled on clk_i while reset_i=1: v_r=0, data_r=0, tag_r=0, last_r=1, so input 0 wins first.
- Reset mid-operation drops the held word. ready_o=0 in every cycle where reset_i=1.
- accept_en = ~v_r | yumi_i. The slot can load in the same cycle it is drained, giving one word per cycle throughput.
- Grant, combinational, one-hot or zero:
  - Neither input valid: gnt=00.
  - Exactly one input valid: gnt selects it.
  - Both inputs valid: gnt selects input (last_r+1) mod 2.
- ready_o = gnt & {els_p{accept_en}}, so at most one ready bit is high.
- ready_o depends combinationally on v_i. Upstream must not derive v_i from ready_o.
- Transfer cycle (|ready_o):
  - data_r <= one-hot-muxed data_i using ready_o as the select.
  - tag_r <= granted index; last_r <= granted index; v_r <= 1.
- No transfer but yumi_i=1: v_r <= 0. data_r, tag_r and last_r hold.
- No transfer and no yumi_i: all state holds. A full slot with yumi_i=0 back-pressures both inputs (ready_o=00).
- last_r updates only on an actual transfer. A stalled grant does not rotate priority.
- Latency: a word accepted in cycle n appears on data_o in cycle n+1.
- Fairness: with both inputs continuously valid and yumi_i held high, grants alternate 0,1,0,1 starting from input 0 after reset. No input waits more than one other transfer.
- Assertions (simulation only):
  - yumi_i=1 while v_o=0 is an error.
  - ready_o not one-hot-or-zero is an error.
  - els_p != 2 is an error.

Decomposition:
- Shared package constant: rr_merge_els_lp = 2.
- Shared package typedef: rr_merge_tag_t, 1 bit, for the source index.
- Natural sub-module: bsg_round_robin_arb_2, holding last_r and producing gnt from v_i and accept_en.
- Datapath selection uses the team's existing 10-bit, 2-way one-hot mux, with the select driven by ready_o.
- Output register and control stay in the top module.

Test Plan:
- Reset then idle: reset_i=1 for 2 cycles, v_i=00 -> v_o=0, data_o=0, tag_o=0, ready_o=00, including during reset.
- Single source: v_i=01, data word0=0x155, yumi_i=1 -> ready_o=01. Next cycle v_o=1, data_o=0x155, tag_o=0.
- Contention and alternation: v_i=11, word0=0x0AA, word1=0x3FF, yumi_i=1 for 4 cycles -> tag_o sequence 0,1,0,1; data_o sequence 0x0AA,0x3FF,0x0AA,0x3FF.
- Back-pressure: slot full, yumi_i=0, v_i=11 for 3 cycles -> ready_o=00, data_o stable, last_r unchanged. Release yumi_i -> grant goes to the input opposite tag_o.
- Simultaneous drain and load: v_r=1, yumi_i=1, v_i=10, word1=0x201 -> ready_o=10. Next cycle v_o=1, data_o=0x201, tag_o=1, with no bubble.
- Reset mid-stream: slot full with 0x155 and v_i=11, assert reset_i for 1 cycle -> next cycle v_o=0, data_o=0. First post-reset grant goes to input 0.
